// File: rtl/p4_mem_stage.sv
// Memory-access stage: one req/ack data-memory transaction per load/store, stalling the pipeline until it completes.
// Non-memory instructions pass straight through combinationally; a timeout abandons a transaction and sets a sticky bus_err.
module p4_mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  type_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [2:0]  type_out,
  output logic [31:0] result_out,
  output logic [4:0]  rd_out,
  output logic        stall_out,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  localparam logic [2:0] T_LOAD   = 3'd2;
  localparam logic [2:0] T_STORE  = 3'd3;
  localparam logic [2:0] T_BUBBLE = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   load_q;
  logic          we_q;
  logic [4:0]    rd_q;
  logic [2:0]    type_q;
  logic          bus_err_q;

  logic mem_op;
  logic aligned;

  assign mem_op  = (type_in == T_LOAD) || (type_in == T_STORE);
  assign aligned = (alu_result[1:0] == 2'b00);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      load_q    <= '0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      type_q    <= T_BUBBLE;
      bus_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_op && aligned) begin
            addr_q  <= alu_result;
            wdata_q <= store_data;
            we_q    <= (type_in == T_STORE);
            rd_q    <= rd_in;
            type_q  <= type_in;
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // An ack on the final allowed cycle still completes the transaction.
          if (dmem_ack) begin
            load_q  <= dmem_rdata;
            state_q <= S_DONE;
          end else if (cnt_q == LAST) begin
            load_q    <= '0;
            bus_err_q <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign bus_err    = bus_err_q;

  always_comb begin
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    type_out     = T_BUBBLE;
    result_out   = '0;
    rd_out       = '0;
    stall_out    = 1'b0;
    misalign_err = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          if (mem_op) begin
            // Aligned access holds the pipeline; misaligned one is squashed to a bubble.
            stall_out    = aligned;
            misalign_err = !aligned;
          end else begin
            type_out   = type_in;
            result_out = alu_result;
            rd_out     = rd_in;
          end
        end
        S_WAIT: begin
          dmem_req  = 1'b1;
          dmem_we   = we_q;
          stall_out = 1'b1;
        end
        S_DONE: begin
          type_out   = type_q;
          rd_out     = rd_q;
          result_out = (type_q == T_LOAD) ? load_q : addr_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_p4_mem_stage.sv
// Directed bench for p4_mem_stage: pass-through, load/store handshakes, misalignment, timeout and reset-in-WAIT.
module tb_p4_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  type_in;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [2:0]  type_out;
  logic [31:0] result_out;
  logic [4:0]  rd_out;
  logic        stall_out;
  logic        misalign_err;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  int stalls;
  int lat;

  p4_mem_stage #(.TIMEOUT(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .type_in      (type_in),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .rd_in        (rd_in),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .type_out     (type_out),
    .result_out   (result_out),
    .rd_out       (rd_out),
    .stall_out    (stall_out),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; drives follow, checks come #1 later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] t, input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r);
    type_in    = t;
    alu_result = a;
    store_data = sd;
    rd_in      = r;
  endtask

  initial begin
    reset = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    drive(3'd0, 32'h1111_2222, 32'h0, 5'd4);

    // Forced outputs while reset is high
    tick(); tick(); #1;
    chk("rst_type_out", 32'(type_out), 32'd7);
    chk("rst_result", result_out, 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);

    // R-ALU pass-through
    tick();
    reset = 1'b0;
    drive(3'd0, 32'h0000_1234, 32'h0, 5'd5);
    #1;
    chk("ralu_type", 32'(type_out), 32'd0);
    chk("ralu_result", result_out, 32'h0000_1234);
    chk("ralu_rd", 32'(rd_out), 32'd5);
    chk("ralu_stall", 32'(stall_out), 32'd0);

    // Load at 0x100, ack on first WAIT cycle
    tick();
    drive(3'd2, 32'h0000_0100, 32'h0, 5'd7);
    #1;
    stalls = 0;
    if (stall_out) stalls++;
    chk("ld_idle_req", 32'(dmem_req), 32'd0);
    tick();
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1;
    if (stall_out) stalls++;
    chk("ld_wait_req", 32'(dmem_req), 32'd1);
    chk("ld_wait_we", 32'(dmem_we), 32'd0);
    chk("ld_wait_addr", dmem_addr, 32'h0000_0100);
    tick();
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    #1;
    chk("ld_stall_count", 32'(stalls), 32'd2);
    chk("ld_done_stall", 32'(stall_out), 32'd0);
    chk("ld_done_req", 32'(dmem_req), 32'd0);
    chk("ld_done_type", 32'(type_out), 32'd2);
    chk("ld_done_result", result_out, 32'hDEAD_BEEF);
    chk("ld_done_rd", 32'(rd_out), 32'd7);

    // Store at 0x40, ack on third WAIT cycle
    tick();
    drive(3'd3, 32'h0000_0040, 32'hCAFE_0001, 5'd0);
    #1;
    stalls = 0;
    if (stall_out) stalls++;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 3) dmem_ack = 1'b1;
      #1;
      if (stall_out) stalls++;
      chk($sformatf("st_wait%0d_we", k), 32'(dmem_we), 32'd1);
      chk($sformatf("st_wait%0d_addr", k), dmem_addr, 32'h0000_0040);
      chk($sformatf("st_wait%0d_wdata", k), dmem_wdata, 32'hCAFE_0001);
    end
    tick();
    dmem_ack = 1'b0;
    #1;
    chk("st_stall_count", 32'(stalls), 32'd4);
    chk("st_done_stall", 32'(stall_out), 32'd0);
    chk("st_done_type", 32'(type_out), 32'd3);
    chk("st_done_result", result_out, 32'h0000_0040);

    // Misaligned load at 0x102
    tick();
    drive(3'd2, 32'h0000_0102, 32'h0, 5'd6);
    #1;
    chk("mis_err", 32'(misalign_err), 32'd1);
    chk("mis_type", 32'(type_out), 32'd7);
    chk("mis_stall", 32'(stall_out), 32'd0);
    chk("mis_req", 32'(dmem_req), 32'd0);
    tick();
    drive(3'd7, 32'h0, 32'h0, 5'd0);
    dmem_ack = 1'b1;
    #1;
    chk("mis_next_err", 32'(misalign_err), 32'd0);
    chk("mis_next_req", 32'(dmem_req), 32'd0);
    tick();
    dmem_ack = 1'b0;
    #1;
    chk("idle_ack_ignored_req", 32'(dmem_req), 32'd0);
    chk("idle_ack_ignored_type", 32'(type_out), 32'd7);

    // Ack on the last allowed WAIT cycle wins over the timeout
    tick();
    drive(3'd2, 32'h0000_0180, 32'h0, 5'd3);
    #1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 16) begin
        dmem_ack = 1'b1;
        dmem_rdata = 32'hA5A5_0F0F;
      end
      #1;
      if (k == 16) chk("late_ack_stall", 32'(stall_out), 32'd1);
    end
    tick();
    dmem_ack = 1'b0;
    #1;
    chk("late_ack_done_stall", 32'(stall_out), 32'd0);
    chk("late_ack_bus_err", 32'(bus_err), 32'd0);
    chk("late_ack_result", result_out, 32'hA5A5_0F0F);

    // Timeout: no ack at all
    tick();
    drive(3'd2, 32'h0000_0200, 32'h0, 5'd9);
    #1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      #1;
      if (k == 16) chk("to_last_wait_bus_err", 32'(bus_err), 32'd0);
      if (!stall_out) begin
        lat = k;
        break;
      end
    end
    chk("to_done_cycle", 32'(lat), 32'd17);
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_type", 32'(type_out), 32'd2);
    chk("to_result", result_out, 32'd0);
    tick();
    drive(3'd1, 32'h0000_0055, 32'h0, 5'd2);
    #1;
    chk("to_sticky_bus_err", 32'(bus_err), 32'd1);
    chk("to_ialu_result", result_out, 32'h0000_0055);

    // Reset asserted in WAIT cycle 2
    tick();
    drive(3'd2, 32'h0000_0300, 32'h0, 5'd8);
    tick();
    tick();
    #1;
    chk("rw_wait2_req", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("rw_forced_req", 32'(dmem_req), 32'd0);
    tick();
    reset = 1'b0;
    drive(3'd7, 32'h0, 32'h0, 5'd0);
    #1;
    chk("rw_after_req", 32'(dmem_req), 32'd0);
    chk("rw_after_type", 32'(type_out), 32'd7);
    chk("rw_after_bus_err", 32'(bus_err), 32'd0);
    chk("rw_after_addr", dmem_addr, 32'd0);
    tick();
    dmem_ack = 1'b1;
    dmem_rdata = 32'hBAD0_BAD0;
    tick();
    dmem_ack = 1'b0;
    #1;
    chk("rw_late_ack_req", 32'(dmem_req), 32'd0);
    chk("rw_late_ack_stall", 32'(stall_out), 32'd0);
    drive(3'd2, 32'h0000_0104, 32'h0, 5'd11);
    #1;
    chk("rw_reload_stall", 32'(stall_out), 32'd1);
    tick();
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1234_5678;
    #1;
    chk("rw_reload_addr", dmem_addr, 32'h0000_0104);
    tick();
    dmem_ack = 1'b0;
    #1;
    chk("rw_reload_type", 32'(type_out), 32'd2);
    chk("rw_reload_result", result_out, 32'h1234_5678);
    chk("rw_reload_rd", 32'(rd_out), 32'd11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/p4_mem_stage.md
# p4_mem_stage

Memory-access stage of the P4 pipeline: sits between the EX/MEM pipeline register and the MEM/WB register, which it feeds directly. For load/store instructions it issues one transaction on a req/ack data-memory port and stalls the pipeline until the transaction completes. Non-memory instructions pass through in zero cycles. Its outputs drive the MEM/WB `type`, `rs2`, `rd` and `stall` inputs.

## Interface
- `TIMEOUT`, default 16: maximum WAIT cycles before a transaction is abandoned (≥2).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `type_in` in 3: instruction class. 0 R-ALU, 1 I-ALU, 2 load, 3 store, 4 branch, 5 jump, 6 LUI, 7 bubble/invalid.
- `alu_result` in 32: EX result; also the memory address for load/store.
- `store_data` in 32: word to store.
- `rd_in` in 5: destination register.
- `dmem_ack` in 1: memory completed the current request; `dmem_rdata` valid in the same cycle.
- `dmem_rdata` in 32: load data.
- `dmem_req` out 1: request active.
- `dmem_we` out 1: 1 = store, 0 = load.
- `dmem_addr` out 32: latched word address.
- `dmem_wdata` out 32: latched store data.
- `type_out` out 3, `result_out` out 32, `rd_out` out 5: to MEM/WB (`result_out` → MEM/WB `rs2`).
- `stall_out` out 1: holds EX/MEM and MEM/WB.
- `misalign_err` out 1: one-cycle flag for a misaligned load/store.
- `bus_err` out 1: sticky flag for a timeout; cleared only by reset.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE, type 2/3, `alu_result[1:0]==0`:
  - Latch addr, wdata, we (type==3), rd and type.
  - Clear the timeout counter and go to WAIT.
  - `stall_out`=1.
- IDLE, type 2/3, misaligned:
  - No transaction; stay in IDLE.
  - `misalign_err`=1 and `stall_out`=0.
  - `type_out`=7, so no writeback occurs.
- IDLE, any other type: combinational pass-through.
  - `type_out`=`type_in`, `result_out`=`alu_result`, `rd_out`=`rd_in`, `stall_out`=0.
- WAIT:
  - `dmem_req`=1, with addr, wdata and we held stable from the latches.
  - `stall_out`=1.
  - Counter increments each cycle.
  - `dmem_ack` sampled high: capture `dmem_rdata` into the load register and go to DONE.
  - Counter reaches TIMEOUT-1 with no ack: set `bus_err`, load register = 0, go to DONE.
  - Ack and timeout in the same cycle: the ack wins and `bus_err` is not set.
- DONE (one cycle):
  - `stall_out`=0, `dmem_req`=0.
  - `type_out`=latched type, `rd_out`=latched rd.
  - `result_out` = load register for a load, or the latched address for a store (MEM/WB ignores it for stores).
  - Next state is IDLE; the following instruction is evaluated next cycle.
- `dmem_req` is decoded from the registered state, with no combinational path from the inputs.
- `dmem_ack` seen outside WAIT is ignored.

## Timing
- Non-memory op: 0 added latency, no stall.
- Load/store, ack in first WAIT cycle: 3 cycles (IDLE, WAIT, DONE) and 2 stall cycles.
- Each extra WAIT cycle adds one stall cycle.
- Timeout path: exactly 1 + TIMEOUT + 1 cycles.
- MEM/WB captures the DONE-cycle outputs on the edge ending DONE.
- Values while `reset` is high (the combinational outputs are forced):
  - `stall_out`=0, `dmem_req`=0, `dmem_we`=0, `misalign_err`=0.
  - `type_out`=7, `result_out`=0, `rd_out`=0.
- Registers after a reset edge:
  - State IDLE, counter 0.
  - addr, wdata and load register 0.
  - `bus_err`=0.
- Reset during WAIT: `dmem_req` is low in the cycle after the reset edge and the transaction is abandoned. Any late ack is ignored.

## Test plan
- R-ALU: type 0, `alu_result`=0x0000_1234, rd 5 → same cycle `type_out`=0, `result_out`=0x1234, `rd_out`=5, `stall_out`=0.
- Load, addr 0x100, ack on first WAIT cycle with rdata 0xDEAD_BEEF:
  - `stall_out`=1 for 2 cycles.
  - DONE cycle: `type_out`=2, `result_out`=0xDEAD_BEEF.
- Store, addr 0x40, data 0xCAFE_0001, ack after 3 WAIT cycles:
  - `dmem_we`=1, addr and wdata stable for all 3 cycles.
  - 4 stall cycles, then DONE with `type_out`=3.
- Misaligned load, addr 0x102:
  - No `dmem_req`.
  - `misalign_err`=1 for 1 cycle, `type_out`=7, `stall_out`=0.
- No ack, TIMEOUT=16:
  - `bus_err` rises, DONE at cycle 17, load `result_out`=0.
  - `bus_err` stays 1 until reset.
- Reset during WAIT cycle 2:
  - Next cycle `dmem_req`=0 and `type_out`=7.
  - An ack one cycle later has no effect; the next load completes normally.
